// File: rtl/rotaryio_poll_ctrl.sv
// AXI4-Lite master for the rotaryio register slave: periodic sweep of all
// registers into an atomic snapshot, with host writes arbitrated in between.
module rotaryio_poll_ctrl #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS         = 4,
  parameter int POLL_PERIOD      = 100000
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          poll_en,
  input  logic                          wr_req,
  input  logic [1:0]                    wr_addr,
  input  logic [31:0]                   wr_data,
  output logic                          wr_ack,
  output logic                          wr_err,
  output logic [32*NUM_REGS-1:0]        snap_data,
  output logic                          snap_valid,
  output logic                          snap_changed,
  output logic                          snap_err,
  output logic                          poll_overrun,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int CNT_W = $clog2(POLL_PERIOD);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, SNAP} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt;
  logic                    tick, poll_pending, sweep_active, first_sweep, sweep_err;
  logic                    sweep_start, wr_start, rd_fire, rd_last, b_fire;
  logic                    aw_done, w_done;
  logic [IDX_W-1:0]        idx;
  logic [1:0]              wr_addr_q;
  logic [31:0]             wr_data_q;
  logic [32*NUM_REGS-1:0]  shadow;
  logic                    unused_resp;

  assign unused_resp  = ^{m_axi_rresp[0], m_axi_bresp[0]};
  assign tick         = poll_en && (cnt == CNT_LAST);
  assign rd_fire      = (state == RDATA) && m_axi_rvalid;
  assign rd_last      = (idx == IDX_LAST);
  assign b_fire       = (state == WRESP) && m_axi_bvalid;

  assign m_axi_awaddr = C_AXI_ADDR_WIDTH'({wr_addr_q, 2'b00});
  assign m_axi_araddr = C_AXI_ADDR_WIDTH'({idx, 2'b00});
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata  = wr_data_q;
  assign m_axi_wstrb  = {(C_AXI_DATA_WIDTH/8){m_axi_wvalid}};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    sweep_start   = 1'b0;
    wr_start      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          wr_start = 1'b1;
          state_nx = WADDR;
        end else if (poll_pending) begin
          sweep_start = 1'b1;
          state_nx    = RADDR;
        end
      end
      WADDR: begin
        // AW and W retire independently; move on once both have handshaken.
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nx = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nx = sweep_active ? RADDR : IDLE;
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = RDATA;
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          if (rd_last) begin
            state_nx = SNAP;
          end else if (wr_req) begin
            wr_start = 1'b1;
            state_nx = WADDR;
          end else begin
            state_nx = RADDR;
          end
        end
      end
      SNAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt          <= '0;
      poll_pending <= 1'b0;
      poll_overrun <= 1'b0;
      sweep_active <= 1'b0;
      first_sweep  <= 1'b1;
      sweep_err    <= 1'b0;
      idx          <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      shadow       <= '0;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      snap_data    <= '0;
      snap_valid   <= 1'b0;
      snap_changed <= 1'b0;
      snap_err     <= 1'b0;
    end else begin
      if (!poll_en || tick) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
      // A tick never queues twice; a collision is only recorded as overrun.
      poll_pending <= tick || (poll_pending && !sweep_start);
      if (tick && (poll_pending || sweep_active)) poll_overrun <= 1'b1;

      if (sweep_start) begin
        sweep_active <= 1'b1;
        idx          <= '0;
      end

      if (wr_start) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else if (state == WADDR) begin
        if (m_axi_awready) aw_done <= 1'b1;
        if (m_axi_wready)  w_done  <= 1'b1;
      end

      if (rd_fire) begin
        shadow[idx*32 +: 32] <= m_axi_rdata[31:0];
        sweep_err            <= sweep_err || m_axi_rresp[1];
        if (!rd_last) idx <= idx + 1'b1;
      end

      wr_ack       <= b_fire;
      wr_err       <= b_fire && m_axi_bresp[1];
      snap_valid   <= (state == SNAP);
      snap_changed <= 1'b0;
      snap_err     <= 1'b0;
      if (state == SNAP) begin
        snap_data    <= shadow;
        snap_changed <= (shadow != snap_data) || first_sweep;
        snap_err     <= sweep_err;
        first_sweep  <= 1'b0;
        sweep_err    <= 1'b0;
        sweep_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotaryio_poll_ctrl.sv
// Directed bench for rotaryio_poll_ctrl: bench-side slave, transaction-level
// snapshot model checked every cycle, plus literal expectations per scenario.
module tb_rotaryio_poll_ctrl;
  localparam int NR = 4;
  localparam int PP = 16;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         poll_en, wr_req;
  logic [1:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         wr_ack, wr_err;
  logic [127:0] snap_data;
  logic         snap_valid, snap_changed, snap_err, poll_overrun;
  logic [3:0]   awaddr, araddr, wstrb;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [1:0]   bresp, rresp;

  rotaryio_poll_ctrl #(
    .C_AXI_ADDR_WIDTH(4), .C_AXI_DATA_WIDTH(32), .NUM_REGS(NR), .POLL_PERIOD(PP)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .poll_en(poll_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .snap_data(snap_data), .snap_valid(snap_valid), .snap_changed(snap_changed),
    .snap_err(snap_err), .poll_overrun(poll_overrun),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 ACLK = ~ACLK;

  int vecs = 0, errs = 0, nsnaps = 0;

  // slave state; *_go are handshakes that will happen at the coming posedge
  logic [31:0]  sregs [NR];
  bit           ar_go, r_go, aw_go, w_go, b_go;
  logic [3:0]   ar_ga, aw_ga;
  logic [1:0]   r_idx, aw_idx;
  logic [31:0]  w_gd, w_d;
  bit           aw_got, w_got, wv_prev, w_lag, berr, rerr_en, stall_seen;
  int           ar_stall;
  logic [7:0]   txlog [$];

  // model: words delivered in the current sweep and the last published snapshot
  logic [31:0]  mw [NR];
  logic [127:0] last_snap, msnap;
  bit           m_first, m_err, exp_ack, exp_berr;
  int           snap_due;

  task automatic chk1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_reset();
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = '0; bresp = '0;
    ar_go = 0; r_go = 0; aw_go = 0; w_go = 0; b_go = 0;
    aw_got = 0; w_got = 0; wv_prev = 0; ar_stall = 0; stall_seen = 0;
  endtask

  task automatic model_reset();
    m_first = 1; m_err = 0; snap_due = 0; exp_ack = 0; exp_berr = 0;
    last_snap = '0;
    for (int i = 0; i < NR; i++) mw[i] = '0;
  endtask

  task automatic slave_tick();
    exp_ack = 0;
    if (r_go) begin
      rvalid = 0;
      mw[r_idx] = rdata;
      m_err = m_err | rresp[1];
      if (r_idx == 2'd3) snap_due = 2;
    end
    if (b_go) begin
      bvalid = 0;
      exp_ack = 1;
    end
    if (ar_go) begin
      r_idx = ar_ga[3:2];
      rvalid = 1;
      rdata = sregs[ar_ga[3:2]];
      rresp = (rerr_en && ar_ga[3:2] == 2'd3) ? 2'b10 : 2'b00;
      txlog.push_back({4'h0, ar_ga});
    end
    if (aw_go) begin
      aw_got = 1;
      aw_idx = aw_ga[3:2];
      txlog.push_back({4'h1, aw_ga});
    end
    if (w_go) begin
      w_got = 1;
      w_d = w_gd;
    end
    if (aw_got && w_got) begin
      sregs[aw_idx] = w_d;
      bvalid = 1;
      bresp = berr ? 2'b10 : 2'b00;
      exp_berr = berr;
      aw_got = 0; w_got = 0;
    end
    if (ar_stall > 0 && arvalid) begin
      arready = 0;
      ar_stall--;
      stall_seen = 1;
    end else begin
      arready = 1;
    end
    awready = 1;
    wready = w_lag ? wv_prev : 1'b1;
    wv_prev = wvalid;
    ar_go = arvalid && arready; ar_ga = araddr;
    r_go  = rvalid && rready;
    aw_go = awvalid && awready; aw_ga = awaddr;
    w_go  = wvalid && wready;   w_gd = wdata;
    b_go  = bvalid && bready;
  endtask

  task automatic check_cycle();
    chk1("ar_aw_exclusive", arvalid && (awvalid || wvalid), 1'b0);
    if (aw_go) chkw("awprot", 128'(awprot), 128'(0));
    if (ar_go) chkw("arprot", 128'(arprot), 128'(0));
    if (w_go)  chkw("wstrb", 128'(wstrb), 128'(4'hF));
    chk1("wr_ack", wr_ack, exp_ack);
    if (wr_ack) chk1("wr_err", wr_err, exp_berr);
    chk1("snap_valid", snap_valid, snap_due == 1);
    if (snap_due == 1) begin
      msnap = {mw[3], mw[2], mw[1], mw[0]};
      chkw("snap_data", snap_data, msnap);
      chk1("snap_changed", snap_changed, m_first || (msnap != last_snap));
      chk1("snap_err", snap_err, m_err);
      last_snap = msnap; m_first = 0; m_err = 0; nsnaps++;
    end else begin
      chkw("snap_hold", snap_data, last_snap);
    end
    if (snap_due > 0) snap_due--;
  endtask

  task automatic step();
    @(negedge ACLK);
    if (!ARESETN) begin
      slave_reset();
      model_reset();
    end else begin
      slave_tick();
      check_cycle();
    end
  endtask

  task automatic wait_snap(input string tag);
    int n = 0;
    do begin step(); n++; end while (!snap_valid && n < 300);
    if (!snap_valid) begin
      vecs++; errs++;
      $display("FAIL %s: snap_valid absent after %0d cycles, required a pulse", tag, n);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [31:0] d, output int lat);
    wr_addr = a; wr_data = d; wr_req = 1; lat = 0;
    do begin step(); lat++; end while (!wr_ack && lat < 200);
    wr_req = 0;
    if (!wr_ack) begin
      vecs++; errs++;
      $display("FAIL wr_ack_timeout: no ack after %0d cycles, required one", lat);
    end
  endtask

  task automatic wait_ar(input logic [1:0] ri);
    int n = 0;
    do begin step(); n++; end while (!(ar_go && ar_ga[3:2] == ri) && n < 200);
    if (!ar_go) begin
      vecs++; errs++;
      $display("FAIL ar_wait: no AR to reg %0d after %0d cycles", ri, n);
    end
  endtask

  initial begin
    int lat, base;
    logic [7:0] exp_log [5];
    ARESETN = 0; poll_en = 0; wr_req = 0; wr_addr = '0; wr_data = '0;
    w_lag = 0; berr = 0; rerr_en = 0;
    for (int i = 0; i < NR; i++) sregs[i] = 32'(i + 1);
    txlog.delete();
    slave_reset(); model_reset();
    repeat (3) step();

    chk1("rst_awvalid", awvalid, 0); chk1("rst_wvalid", wvalid, 0);
    chk1("rst_bready", bready, 0);   chk1("rst_arvalid", arvalid, 0);
    chk1("rst_rready", rready, 0);   chk1("rst_wr_ack", wr_ack, 0);
    chk1("rst_snap_valid", snap_valid, 0); chk1("rst_overrun", poll_overrun, 0);
    chkw("rst_wstrb", 128'(wstrb), 128'(0));
    chkw("rst_snap_data", snap_data, 128'(0));

    // first sweep after reset always reports a change
    ARESETN = 1; poll_en = 1;
    wait_snap("snap1");
    chkw("snap1_data", snap_data, {32'h4, 32'h3, 32'h2, 32'h1});
    chk1("snap1_changed", snap_changed, 1);
    chk1("snap1_err", snap_err, 0);
    wait_snap("snap2");
    chk1("snap2_changed", snap_changed, 0);

    // host write on an idle bus
    poll_en = 0;
    host_write(2'd2, 32'hA5, lat);
    chkw("wr_latency", 128'(lat), 128'(3));
    chk1("wr1_err", wr_err, 0);
    poll_en = 1;
    wait_snap("snap3");
    chkw("snap3_data", snap_data, {32'h4, 32'hA5, 32'h2, 32'h1});
    chk1("snap3_changed", snap_changed, 1);

    // host write interleaved after the read of reg1
    txlog.delete();
    wait_ar(2'd1);
    host_write(2'd2, 32'h5A, lat);
    chk1("wr2_err", wr_err, 0);
    wait_snap("snap4");
    exp_log = '{8'h00, 8'h04, 8'h18, 8'h08, 8'h0C};
    chkw("txlog_len", 128'(txlog.size()), 128'(5));
    for (int i = 0; i < 5 && i < txlog.size(); i++) chkw("txlog_entry", 128'(txlog[i]), 128'(exp_log[i]));
    chkw("snap4_data", snap_data, {32'h4, 32'h5A, 32'h2, 32'h1});

    // slave errors: SLVERR on a write response and on reg3 read data
    poll_en = 0; berr = 1; w_lag = 1;
    host_write(2'd0, 32'h11, lat);
    chk1("wr3_err", wr_err, 1);
    berr = 0; w_lag = 0; rerr_en = 1; poll_en = 1;
    wait_snap("snap5");
    chk1("snap5_err", snap_err, 1);
    chkw("snap5_data", snap_data, {32'h4, 32'h5A, 32'h2, 32'h11});
    rerr_en = 0;
    wait_snap("snap6");
    chk1("snap6_err", snap_err, 0);
    chk1("snap6_changed", snap_changed, 0);

    // arready stall longer than two poll periods
    chk1("overrun_before", poll_overrun, 0);
    ar_stall = 40; stall_seen = 0;
    begin
      int n = 0;
      do begin step(); n++; end while (!stall_seen && n < 100);
    end
    base = nsnaps;
    repeat (36) step();
    poll_en = 0;
    repeat (150) step();
    chkw("stall_sweeps", 128'(nsnaps - base), 128'(2));
    chk1("overrun_after", poll_overrun, 1);

    // reset in the middle of a read data phase
    poll_en = 1;
    wait_ar(2'd2);
    step();
    chk1("in_rdata", rready, 1);
    #2 ARESETN = 0;
    #1;
    chk1("arst_rready", rready, 0);   chk1("arst_arvalid", arvalid, 0);
    chk1("arst_awvalid", awvalid, 0); chk1("arst_wvalid", wvalid, 0);
    chk1("arst_bready", bready, 0);   chk1("arst_overrun", poll_overrun, 0);
    chkw("arst_snap_data", snap_data, 128'(0));
    repeat (2) step();
    ARESETN = 1;
    wait_snap("snap7");
    chk1("snap7_changed", snap_changed, 1);
    chkw("snap7_data", snap_data, {32'h4, 32'h5A, 32'h2, 32'h11});
    chk1("snap7_err", snap_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
